// File: rtl/app_mul_pkg.sv
// Shared constants, FSM state type and radix-4 digit decode for the iterative
// signed 16x16 multiplier.
package app_mul_pkg;
  localparam int W     = 16;
  localparam int ITER  = W / 2;
  localparam int P_W   = 2 * W;
  localparam int PP_W  = W + 2;
  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Slice value: 2*bh + bl (0..3), or -2*bh + bl on the signed top slice.
  function automatic logic signed [2:0] digit_value(input logic b_high,
                                                    input logic b_low,
                                                    input logic last_signed);
    logic signed [2:0] v;
    if (last_signed) v = $signed({b_high, b_high, b_low});
    else             v = $signed({1'b0, b_high, b_low});
    return v;
  endfunction
endpackage

// File: rtl/app_mul_pp2_layer.sv
// One radix-4 partial-product layer: pp = A * digit, exact, 18-bit signed.
module app_mul_pp2_layer
  import app_mul_pkg::*;
(
  input  logic signed [W-1:0]    a,
  input  logic                   b_low,
  input  logic                   b_high,
  input  logic                   last_signed,
  output logic signed [PP_W-1:0] pp
);
  logic signed [2:0]      digit;
  logic signed [PP_W-1:0] a_ext;
  logic signed [PP_W-1:0] d_ext;

  assign digit = digit_value(b_high, b_low, last_signed);
  assign a_ext = $signed({{(PP_W-W){a[W-1]}}, a});
  assign d_ext = $signed({{(PP_W-3){digit[2]}}, digit});
  // |A*digit| <= 3*2^15, so the 18-bit product never wraps.
  assign pp    = a_ext * d_ext;
endmodule

// File: rtl/app_mul_seq_ctrl.sv
// Iterative signed multiplier controller: one 2-bit slice of B per cycle,
// valid/ready on both sides, all outputs registered.
module app_mul_seq_ctrl #(
  parameter int W    = 16,
  parameter int ITER = W / 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  input  logic           in_b_signed,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_p,
  output logic           busy,
  output logic [2:0]     iter_cnt
);
  import app_mul_pkg::P_W;
  import app_mul_pkg::PP_W;
  import app_mul_pkg::CNT_W;
  import app_mul_pkg::state_t;
  import app_mul_pkg::IDLE;
  import app_mul_pkg::RUN;
  import app_mul_pkg::DONE;

  if (W != 16 || ITER != W / 2) begin : g_bad_width
    $error("app_mul_seq_ctrl supports only W=16");
  end

  state_t                 state;
  logic signed [W-1:0]    a_reg;
  logic [W-1:0]           b_reg;
  logic                   b_signed_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic [P_W-1:0]         acc_reg;
  logic [P_W-1:0]         out_p_reg;
  logic                   in_ready_reg;
  logic                   out_valid_reg;
  logic                   busy_reg;

  logic [ITER-1:0]        b_lo_slices;
  logic [ITER-1:0]        b_hi_slices;
  logic                   last_slice;
  logic signed [PP_W-1:0] pp;
  logic [P_W-1:0]         pp_ext;
  logic [P_W-1:0]         acc_next;

  for (genvar gi = 0; gi < ITER; gi++) begin : g_slice
    assign b_lo_slices[gi] = b_reg[2*gi];
    assign b_hi_slices[gi] = b_reg[2*gi+1];
  end

  assign last_slice = (cnt_reg == CNT_W'(ITER - 1));

  app_mul_pp2_layer u_layer (
    .a           (a_reg),
    .b_low       (b_lo_slices[cnt_reg]),
    .b_high      (b_hi_slices[cnt_reg]),
    .last_signed (b_signed_reg & last_slice),
    .pp          (pp)
  );

  assign pp_ext   = {{(P_W-PP_W){pp[PP_W-1]}}, pp};
  assign acc_next = acc_reg + (pp_ext << {cnt_reg, 1'b0});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      b_signed_reg  <= 1'b0;
      cnt_reg       <= '0;
      acc_reg       <= '0;
      out_p_reg     <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg        <= $signed(in_a);
            b_reg        <= in_b;
            b_signed_reg <= in_b_signed;
            acc_reg      <= '0;
            cnt_reg      <= '0;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            state        <= RUN;
          end
        end
        RUN: begin
          acc_reg <= acc_next;
          if (last_slice) begin
            out_p_reg     <= acc_next;
            out_valid_reg <= 1'b1;
            state         <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          // in_ready stays low through the handshake cycle; no accept/emit overlap.
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
            cnt_reg       <= '0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_p     = out_p_reg;
  assign busy      = busy_reg;
  assign iter_cnt  = cnt_reg;
endmodule
